instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
Sequential program loader and the encode-side counterpart of the single-cycle core's instruction decoder. It accepts field-level instruction descriptors over a valid/ready stream and packs each one into a 32-bit RV32I word. Only the subset the core decodes is supported: load, store, R-type, I-type ALU, branch and JAL. Each encoded word is written to consecutive instruction-memory words starting at 0, so test programs can be built in-system without a hex file.

Parameters:
ADDR_W, 6, instruction-memory word-address width
MEM_WORDS, 64, capacity in words (must be no greater than 2^ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a load session at word 0
finish  in  1  pulse; ends the session after any pending write
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid&&in_ready
in_kind  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 ITYPE, 4 BRANCH, 5 JAL, 6-7 illegal
in_funct3  in  3  funct3 field
in_funct7b5  in  1  funct7[5] (sub/sra/srai select)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  21  signed immediate in two's complement (byte offset for BRANCH/JAL)
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written this session
busy  out  1  session active
done  out  1  session complete (sticky until start/rst)
err  out  1  sticky illegal descriptor flag

Behaviour:
- Reset: state IDLE. All outputs are 0: in_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err. The pending-write register is cleared.
- FSM states:
  - IDLE: start leads to ACCEPT.
  - ACCEPT: in_ready = (acc_cnt < MEM_WORDS). acc_cnt counts accepted descriptors.
  - DRAIN: one cycle to retire the pending write, then DONE.
  - DONE: waits for start.
  - ERROR: waits for start.
- start, in any non-reset state: acc_cnt, count and imem_addr go to 0. done and err clear. Any pending write is discarded (imem_we=0 next cycle). Next state is ACCEPT. start has priority over finish and in_valid in the same cycle.
- Latency: a descriptor accepted in cycle N produces imem_we=1 in cycle N+1, with imem_addr = previous count and imem_wdata = the encoded word. count increments in N+1. Back-to-back accepts give one write per cycle.
- ACCEPT to DRAIN: on finish, or when acc_cnt reaches MEM_WORDS. If finish and an accept occur together, the descriptor is accepted and written.
- DRAIN to DONE after one cycle. done=1 and busy=0 in DONE.
- busy = 1 in ACCEPT and DRAIN.
- Encoding (opcode; field layout):
  - LOAD (0000011): imm[11:0], rs1, f3, rd.
  - ITYPE (0010011): as LOAD, except when f3 is 001 or 101 the top bits [31:25] are {0, funct7b5, 00000} and [24:20] are imm[4:0].
  - STORE (0100011): imm[11:5], rs2, rs1, f3, imm[4:0].
  - RTYPE (0110011): {0, funct7b5, 00000}, rs2, rs1, f3, rd.
  - BRANCH (1100011): imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11].
  - JAL (1101111): imm[20], imm[10:1], imm[11], imm[19:12], rd.
- Error condition: an illegal kind or an out-of-range immediate sets err.
  - LOAD, STORE and non-shift ITYPE: in_imm must be in -2048..2047.
  - Shifts: in_imm must be in 0..31.
  - BRANCH: in_imm must be in -4096..4094 and even.
  - JAL: in_imm must be even (full 21-bit range).
  - Response to an error: the descriptor is consumed (handshake completes), no write is issued, acc_cnt does not advance, and the next state is ERROR. Any pending write from the previous cycle still completes.
- rst in mid-session aborts immediately. No write is issued in the reset cycle or the cycle after it.

Test Plan:
- rst, start; RTYPE f3=0 b5=0 rd=3 rs1=1 rs2=2 -> one cycle later imem_we=1, addr=0, wdata=0x002081B3, count=1.
- Back-to-back stream:
  - RTYPE b5=1 (same regs) -> 0x402081B3
  - LOAD f3=2 rd=5 rs1=2 imm=8 -> 0x00812283
  - STORE f3=2 rs1=2 rs2=5 imm=12 -> 0x00512623
  - Expected: addresses 0..2 in consecutive cycles.
- BRANCH f3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=8 -> 0x008000EF; then finish -> DRAIN then DONE, done=1, busy=0.
- MEM_WORDS=4, hold in_valid for 6 descriptors -> exactly 4 accepted, in_ready=0 after the 4th, count=4, done=1.
- BRANCH imm=3 -> no write, err=1, state ERROR, in_ready=0; start -> err=0, count=0, next descriptor written at addr 0.
- start asserted in the same cycle as an accepted descriptor's write slot -> that write is suppressed, count=0; rst mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream and instruction-memory write bus shared by the loader
// and whatever feeds it (a bring-up controller or a testbench).
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [20:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Program loader: packs field-level descriptors into RV32I words (load, store,
// R-type, I-type ALU, branch, JAL) and writes them to consecutive
// instruction-memory words starting at 0. One registered write stage sits
// between the accept handshake and the memory strobe.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int MEM_WORDS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    finish,
  instr_encoder_loader_if.slave   bus,
  output logic [ADDR_W:0]         count,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_DRAIN, S_DONE, S_ERROR} state_t;

  localparam logic [2:0] K_LOAD   = 3'd0;
  localparam logic [2:0] K_STORE  = 3'd1;
  localparam logic [2:0] K_RTYPE  = 3'd2;
  localparam logic [2:0] K_ITYPE  = 3'd3;
  localparam logic [2:0] K_BRANCH = 3'd4;
  localparam logic [2:0] K_JAL    = 3'd5;

  localparam logic [ADDR_W:0] MEM_WORDS_C = (ADDR_W+1)'(MEM_WORDS);

  state_t              state_reg, state_next;
  // Words written and descriptors accepted always move together (an accept
  // produces exactly one write one cycle later), so a single counter serves both.
  logic [ADDR_W:0]     count_reg, count_next, count_inc;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;

  logic                accept;
  logic                legal;
  logic [31:0]         enc_word;
  logic signed [20:0]  imm_s;
  logic                is_shift;

  assign imm_s     = bus.in_imm;
  assign is_shift  = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
  assign count_inc = count_reg + 1'b1;
  assign accept    = bus.in_valid && bus.in_ready;

  // Encode the current descriptor and decide whether its immediate fits the format.
  always_comb begin
    enc_word = 32'd0;
    legal    = 1'b0;
    case (bus.in_kind)
      K_LOAD: begin
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
        legal    = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
      end
      K_ITYPE: begin
        if (is_shift) begin
          enc_word = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'b0010011};
          legal    = (imm_s >= 21'sd0) && (imm_s <= 21'sd31);
        end else begin
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
          legal    = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
        end
      end
      K_STORE: begin
        enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], 7'b0100011};
        legal    = (imm_s >= -21'sd2048) && (imm_s <= 21'sd2047);
      end
      K_RTYPE: begin
        enc_word = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, bus.in_rd, 7'b0110011};
        legal    = 1'b1;
      end
      K_BRANCH: begin
        enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        legal    = (imm_s >= -21'sd4096) && (imm_s <= 21'sd4094) && !bus.in_imm[0];
      end
      K_JAL: begin
        enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, 7'b1101111};
        legal    = !bus.in_imm[0];
      end
      default: begin
        enc_word = 32'd0;
        legal    = 1'b0;
      end
    endcase
  end

  // Next-state and write-stage logic; start overrides everything else.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    if (start) begin
      state_next = S_ACCEPT;
      count_next = '0;
      addr_next  = '0;
    end else begin
      case (state_reg)
        S_ACCEPT: begin
          if (accept && !legal) begin
            state_next = S_ERROR;
          end else begin
            if (accept) begin
              we_next    = 1'b1;
              addr_next  = count_reg[ADDR_W-1:0];
              wdata_next = enc_word;
              count_next = count_inc;
            end
            if (finish || (accept && (count_inc >= MEM_WORDS_C)) || (count_reg >= MEM_WORDS_C))
              state_next = S_DRAIN;
          end
        end
        S_DRAIN: state_next = S_DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  // State and write-stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // The strobe is masked during reset so an abort never lets a stale write through.
  assign bus.imem_we    = we_reg && !rst;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign bus.in_ready   = (state_reg == S_ACCEPT) && (count_reg < MEM_WORDS_C);
  assign count          = count_reg;
  assign busy           = (state_reg == S_ACCEPT) || (state_reg == S_DRAIN);
  assign done           = (state_reg == S_DONE);
  assign err            = (state_reg == S_ERROR);

endmodule
